hdmi_subpacket_serializer: RTL
==============================

# hdmi_subpacket_serializer

Serializes one 56-bit HDMI data island subpacket into the 2-bit-per-pixel-clock lane stream and appends its 8 BCH parity bits. Each transmission is 32 clocks: 28 data clocks followed by 4 parity clocks. The block sits between the packet builder, which supplies whole subpackets over a valid/ready handshake, and the TMDS channel 1/2 data-island bit mapper. It owns the BCH ECC encoder for its lane and sequences it, so downstream logic sees a complete, self-contained subpacket stream.

## Interface
Parameters:
- `SUBPACKET_BITS`, 56: payload bits per subpacket; fixed by HDMI; must be even.
- `PARITY_BITS`, 8: BCH parity bits appended; fixed by HDMI.

Ports:
- `clock`  in  1  pixel clock; all logic on the rising edge.
- `nReset`  in  1  reset; synchronous, active-low.
- `subpacketData`  in  56  subpacket payload; bit 0 is transmitted first.
- `subpacketValid`  in  1  `subpacketData` is offered.
- `subpacketReady`  out  1  block accepts `subpacketData` this cycle.
- `laneBits`  out  2  lane bits for this clock; bit 0 is the earlier bit.
- `laneValid`  out  1  `laneBits` carries subpacket content.
- `laneFirst`  out  1  first clock (slot 0) of a 32-clock subpacket.
- `laneLast`  out  1  last clock (slot 31) of a subpacket.

## Operation
- **Handshake.** A subpacket transfers on a rising edge where `subpacketValid && subpacketReady`. The source must hold data and valid stable until the transfer.
- **States.**
  - IDLE: `laneValid` is 0.
  - SEND: a 5-bit slot counter runs 0..31.
- **IDLE to SEND.** On transfer, the payload loads a 56-bit shift register and the slot counter is cleared to 0.
- **Data slots (0..27).**
  - Encoder data input = shift[1:0]; `laneBits` = shift[1:0].
  - The shift register moves right by 2 each clock.
  - Encoder first-clock input is asserted only in slot 0, which discards the previous subpacket's residue.
- **Parity slots (28..31).**
  - Encoder data input is held at 2'b00.
  - `laneBits` = encoder ecc output, so 8 parity bits leave in 4 clocks.
- **Leaving slot 31.**
  - If a new subpacket transfers on that same edge (or, with preload, one is pending), go to slot 0 of that subpacket with no gap.
  - Otherwise go to IDLE.
- **Ready, without preload.** `subpacketReady` = IDLE || slot==31, combinational from state.
- **Misuse.** `subpacketValid` dropping mid-transfer is illegal; no checking is done.

## Timing
- **Reset values** (the cycle after `nReset` is sampled low):
  - `laneBits`=0, `laneValid`=0, `laneFirst`=0, `laneLast`=0.
  - State IDLE; shift register and preload buffer cleared.
  - `subpacketReady`=0 while `nReset` is low; 1 in the first cycle after release.
- **Latency.** Slot 0 appears in the cycle after the accepting edge.
- **Output alignment.** `laneBits`, `laneValid`, `laneFirst` and `laneLast` are decoded from registered state, with no extra pipeline stage. `laneFirst` is high exactly in slot 0 and `laneLast` exactly in slot 31.
- **Back-to-back.** Back-to-back subpackets are contiguous: slot 31 is followed immediately by slot 0 with `laneValid` held high.
- **Reset mid-subpacket.** Aborts the subpacket. `laneValid` falls the next cycle, and the partial subpacket is never resumed.
- **Encoder pipelining.** Encoder state updates every clock, including IDLE. The first-clock flag makes the state left in IDLE irrelevant.

## Configuration
- `HDMI_SUBPACKET_PRELOAD_EN` defined:
  - Adds a one-entry holding buffer with a `pendingValid` flag; `subpacketReady` = !`pendingValid`.
  - A subpacket accepted during SEND is held and launched at the next slot 0.
  - Simultaneous accept and launch on the slot-31 edge is allowed: the buffer swaps.
  - In IDLE, an accepted subpacket bypasses the buffer.
- Not defined: no buffer; ready behaves as described in Operation.
- Lane output is identical in both builds for identical accepted data.

## Structure
- **Shared package** (HDMI data island constants): `SUBPACKET_BITS`, `PARITY_BITS`, `DATA_SLOTS`=28, `TOTAL_SLOTS`=32, and the state enum {IDLE, SEND}.
- **Sub-module:** one instance of the existing `BchEccDualBitEncoder`.
  - Its data input is driven from the mux described in Operation.
  - Its first-clock input is driven from slot==0 && SEND.
  - Its ecc output feeds the parity slots.
  - No other logic is pulled into a sub-module.

## Test plan
- **Reset then one all-zero subpacket** → `laneFirst` at cycle 1 and `laneLast` at cycle 32, after which `laneValid` returns to 0. All 32 `laneBits` are 2'b00.
- **`subpacketData`=56'h1** → slot 0 `laneBits`=2'b01 and slots 1..27 are 2'b00. Slots 28..31 equal the golden software BCH model's parity for 56'h1 (LSbit-first pairs).
- **Linearity check** with A=56'h00FF_00FF_00FF_00, B=56'hA5A5_A5A5_A5A5_A5, sent back-to-back with C=A^B → parity(C) == parity(A)^parity(B). There is no idle gap between subpackets, and the residue from A does not leak into B.
- **`nReset` low at slot 13** → the next cycle shows `laneValid`=0 and `subpacketReady`=0. After release, a fresh 56'hFF_FFFF_FFFF_FFFF yields slots 0..27 = 2'b11 and model-correct parity.
- **With `HDMI_SUBPACKET_PRELOAD_EN`, valid held high from cycle 0 with three subpackets** → `subpacketReady` drops after the second acceptance and rises at the slot-31 edge. The output is 96 contiguous valid clocks.
- **Without the macro, valid asserted at slot 10** → ready stays 0 until slot 31, the transfer happens on the slot-31 edge, and the next slot 0 is contiguous.

Source files
------------

// File: rtl/hdmi_subpacket_serializer_pkg.sv
// HDMI data island subpacket constants and the serializer state encoding.
package hdmi_subpacket_serializer_pkg;

  localparam int SUBPACKET_BITS = 56;
  localparam int PARITY_BITS    = 8;
  localparam int DATA_SLOTS     = SUBPACKET_BITS / 2;
  localparam int TOTAL_SLOTS    = DATA_SLOTS + PARITY_BITS / 2;
  localparam int SLOT_W         = $clog2(TOTAL_SLOTS);

  localparam logic [SLOT_W-1:0] FIRST_PARITY_SLOT = SLOT_W'(DATA_SLOTS);
  localparam logic [SLOT_W-1:0] LAST_SLOT         = SLOT_W'(TOTAL_SLOTS - 1);

  // Generator x^8+x^7+x^6+1 in bit-reflected form (first bit sent = highest degree).
  localparam logic [PARITY_BITS-1:0] BCH_POLY_REFLECTED = 8'h83;

  typedef enum logic {
    IDLE,
    SEND
  } stateT;

endpackage

// File: rtl/hdmi_subpacket_serializer_if.sv
// Subpacket handshake plus lane stream between packet builder, serializer and bit mapper.
interface hdmi_subpacket_serializer_if #(
  parameter int SUBPACKET_BITS = hdmi_subpacket_serializer_pkg::SUBPACKET_BITS
);

  logic [SUBPACKET_BITS-1:0] subpacketData;
  logic                      subpacketValid;
  logic                      subpacketReady;
  logic [1:0]                laneBits;
  logic                      laneValid;
  logic                      laneFirst;
  logic                      laneLast;

  modport master (
    output subpacketData,
    output subpacketValid,
    input  subpacketReady,
    input  laneBits,
    input  laneValid,
    input  laneFirst,
    input  laneLast
  );

  modport slave (
    input  subpacketData,
    input  subpacketValid,
    output subpacketReady,
    output laneBits,
    output laneValid,
    output laneFirst,
    output laneLast
  );

endinterface

// File: rtl/hdmi_subpacket_serializer_bch.sv
// BchEccDualBitEncoder: BCH(64,56) parity over two bits per clock; after the data
// clocks the remainder is shifted out two bits per clock on ecc.
module BchEccDualBitEncoder
  import hdmi_subpacket_serializer_pkg::*;
(
  input  logic       clock,
  input  logic       firstClock,
  input  logic [1:0] dataIn,
  output logic [1:0] ecc
);

  logic [PARITY_BITS-1:0] remainder;
  logic [SLOT_W-1:0]      clockCount;

  function automatic logic [PARITY_BITS-1:0] bchStep(input logic [PARITY_BITS-1:0] r,
                                                     input logic                   b);
    return (r >> 1) ^ ((r[0] ^ b) ? BCH_POLY_REFLECTED : '0);
  endfunction

  // firstClock restarts from a zero remainder, so residue left in IDLE never matters.
  always_ff @(posedge clock) begin
    if (firstClock) begin
      remainder  <= bchStep(bchStep('0, dataIn[0]), dataIn[1]);
      clockCount <= SLOT_W'(1);
    end else if (clockCount < FIRST_PARITY_SLOT) begin
      remainder  <= bchStep(bchStep(remainder, dataIn[0]), dataIn[1]);
      clockCount <= clockCount + SLOT_W'(1);
    end else begin
      remainder <= remainder >> 2;
      if (clockCount != LAST_SLOT) begin
        clockCount <= clockCount + SLOT_W'(1);
      end
    end
  end

  assign ecc = remainder[1:0];

endmodule

// File: rtl/hdmi_subpacket_serializer.sv
// Serializes a 56-bit subpacket into 28 data + 4 BCH parity lane clocks.
// Optional build macro HDMI_SUBPACKET_PRELOAD_EN adds a one-entry holding buffer.
module hdmi_subpacket_serializer #(
  parameter int SUBPACKET_BITS = hdmi_subpacket_serializer_pkg::SUBPACKET_BITS,
  parameter int PARITY_BITS    = hdmi_subpacket_serializer_pkg::PARITY_BITS
) (
  input  logic                              clock,
  input  logic                              nReset,
  hdmi_subpacket_serializer_if.slave        bus
);

  import hdmi_subpacket_serializer_pkg::*;

  localparam logic [SLOT_W-1:0] DATA_END  = SLOT_W'(SUBPACKET_BITS / 2);
  localparam logic [SLOT_W-1:0] END_SLOT  = SLOT_W'(SUBPACKET_BITS / 2 + PARITY_BITS / 2 - 1);

  stateT                     state;
  logic [SLOT_W-1:0]         slot;
  logic [SUBPACKET_BITS-1:0] shiftReg;
  logic [1:0]                encData;
  logic [1:0]                eccBits;
  logic                      sending;
  logic                      inData;
  logic                      atLast;
  logic                      atFirst;
  logic                      ready;
  logic                      accept;

  assign sending = (state == SEND);
  assign inData  = (slot < DATA_END);
  assign atLast  = (slot == END_SLOT);
  assign atFirst = sending && (slot == '0);
  assign accept  = bus.subpacketValid && ready;

  assign bus.subpacketReady = ready;
  assign bus.laneValid      = sending;
  assign bus.laneFirst      = atFirst;
  assign bus.laneLast       = sending && atLast;
  assign bus.laneBits       = !sending ? 2'b00 : (inData ? shiftReg[1:0] : eccBits);

  // Zeros during parity slots let the encoder shift its remainder out cleanly.
  assign encData = (sending && inData) ? shiftReg[1:0] : 2'b00;

  BchEccDualBitEncoder encoder (
    .clock      (clock),
    .firstClock (atFirst),
    .dataIn     (encData),
    .ecc        (eccBits)
  );

`ifdef HDMI_SUBPACKET_PRELOAD_EN
  logic                      pendingValid;
  logic [SUBPACKET_BITS-1:0] pendingData;

  assign ready = nReset && !pendingValid;

  always_ff @(posedge clock) begin
    if (!nReset) begin
      state        <= IDLE;
      slot         <= '0;
      shiftReg     <= '0;
      pendingValid <= 1'b0;
      pendingData  <= '0;
    end else if (!sending) begin
      if (accept) begin
        state    <= SEND;
        slot     <= '0;
        shiftReg <= bus.subpacketData;
      end
    end else begin
      slot     <= slot + SLOT_W'(1);
      shiftReg <= shiftReg >> 2;
      if (atLast) begin
        slot <= '0;
        // Launch the held subpacket; an accept on this same edge refills the buffer.
        if (pendingValid) begin
          shiftReg     <= pendingData;
          pendingValid <= accept;
          if (accept) begin
            pendingData <= bus.subpacketData;
          end
        end else if (accept) begin
          shiftReg <= bus.subpacketData;
        end else begin
          state <= IDLE;
        end
      end else if (accept) begin
        pendingValid <= 1'b1;
        pendingData  <= bus.subpacketData;
      end
    end
  end
`else
  assign ready = nReset && (!sending || atLast);

  always_ff @(posedge clock) begin
    if (!nReset) begin
      state    <= IDLE;
      slot     <= '0;
      shiftReg <= '0;
    end else if (!sending) begin
      if (accept) begin
        state    <= SEND;
        slot     <= '0;
        shiftReg <= bus.subpacketData;
      end
    end else begin
      slot     <= slot + SLOT_W'(1);
      shiftReg <= shiftReg >> 2;
      if (atLast) begin
        slot <= '0;
        if (accept) begin
          shiftReg <= bus.subpacketData;
        end else begin
          state <= IDLE;
        end
      end
    end
  end
`endif

endmodule
